// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: single-word valid/ready data-memory bus between an initiator and a slave
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
interface uart_bus_bridge_if;
  logic                         valid_o;
  logic                         ready_i;
  logic [`RISCV_ADDR_WIDTH-1:0] addr_o;
  logic [`RISCV_WORD_WIDTH-1:0] wdata_o;
  logic [3:0]                   we_o;
  logic [`RISCV_WORD_WIDTH-1:0] rdata_i;
  modport master (output valid_o, addr_o, wdata_o, we_o, input ready_i, rdata_i);
  modport slave  (input valid_o, addr_o, wdata_o, we_o, output ready_i, rdata_i);
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART byte-stream command parser driving single-word bus reads/writes.
// Optional trailing XOR checksum byte per command when UART_BUS_BRIDGE_CSUM_EN is defined.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
module uart_bus_bridge #(
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  uart_bus_bridge_if.master bus
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, RSP_K = 8'h4B, RSP_E = 8'h45;
`ifdef UART_BUS_BRIDGE_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP, S_CSUM} state_t;
  localparam state_t S_LAST = S_CSUM;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
  localparam state_t S_LAST = S_BUS;
`endif
  state_t                       state_q;
  logic [1:0]                   cnt_q;
  logic                         wr_q, err_q, valid_q, tx_start_q;
  logic [3:0]                   we_q;
  logic [`RISCV_ADDR_WIDTH-1:0] addr_q;
  logic [`RISCV_WORD_WIDTH-1:0] wdata_q, rsp_q;
  logic [7:0]                   tx_byte_q, rsp_d;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic                         expire, rsp_last;
  assign tmo_d    = &tmo_q ? tmo_q : tmo_q + 1'b1;
  assign expire   = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
  assign rsp_d    = err_q ? RSP_E : wr_q ? RSP_K : rsp_q[{cnt_q, 3'b000} +: 8];
  assign rsp_last = err_q || wr_q || cnt_q == 2'd3;
  assign busy_o      = state_q != S_IDLE;
  assign tx_start_o  = tx_start_q;
  assign tx_byte_o   = tx_byte_q;
  assign bus.valid_o = valid_q;
  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.we_o    = we_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      tx_start_q <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_q      <= '0;
      tx_byte_q  <= '0;
      tmo_q      <= '0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (rx_valid_i && (rx_byte_i == OP_W || rx_byte_i == OP_R)) begin
          state_q <= S_ADDR;
          wr_q    <= rx_byte_i == OP_W;
          err_q   <= 1'b0;
          cnt_q   <= '0;
          tmo_q   <= '0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
          csum_q  <= rx_byte_i;
`endif
        end
        S_ADDR, S_DATA: if (rx_valid_i) begin
          if (state_q == S_ADDR) addr_q[{cnt_q, 3'b000} +: 8] <= rx_byte_i;
          else wdata_q[{cnt_q, 3'b000} +: 8] <= rx_byte_i;
          cnt_q <= cnt_q + 1'b1;
          tmo_q <= '0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
          csum_q <= csum_q ^ rx_byte_i;
`endif
          if (cnt_q == 2'd3) state_q <= (state_q == S_ADDR && wr_q) ? S_DATA : S_LAST;
        end else if (expire) state_q <= S_IDLE;
        else tmo_q <= tmo_d;
`ifdef UART_BUS_BRIDGE_CSUM_EN
        S_CSUM: if (rx_valid_i) begin
          state_q <= rx_byte_i == csum_q ? S_BUS : S_RESP;
          err_q   <= rx_byte_i != csum_q;
          cnt_q   <= '0;
        end else if (expire) state_q <= S_IDLE;
        else tmo_q <= tmo_d;
`endif
        S_BUS: if (valid_q && bus.ready_i) begin
          valid_q <= 1'b0;
          we_q    <= '0;
          rsp_q   <= bus.rdata_i;
          cnt_q   <= '0;
          state_q <= S_RESP;
        end else if (!valid_q) begin
          valid_q <= 1'b1;
          we_q    <= wr_q ? 4'hF : 4'h0;
        end
        // the one-cycle guard after each pulse hides the transmitter's busy latency
        S_RESP: if (!tx_busy_i && !tx_start_q) begin
          tx_start_q <= 1'b1;
          tx_byte_q  <= rsp_d;
          cnt_q      <= cnt_q + 1'b1;
          if (rsp_last) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Bus initiator driven by the UART. Takes a received byte stream from the uart core, parses fixed-format read/write commands, issues single-word transactions on the valid/ready data-memory bus, and returns responses through the uart core transmitter.
- Used as a debug/program loader. Sits between the uart core byte interface and a bus arbiter master port, so its transactions can target any slave, including the UART peripheral itself.

Parameters:
- TIMEOUT, 1000000, idle clock cycles allowed between bytes of one command before it is aborted; 0 disables the timeout.

Ports:
- clk  input  1  master clock
- rst_n  input  1  synchronous reset, active low
- rx_valid_i  input  1  one-cycle pulse: byte received (uart core received)
- rx_byte_i  input  8  received byte, valid with rx_valid_i
- tx_start_o  output  1  one-cycle pulse: transmit tx_byte_o (uart core transmit)
- tx_byte_o  output  8  byte to transmit, stable while tx_start_o high
- tx_busy_i  input  1  transmitter busy (uart core is_transmitting)
- valid_o  output  1  bus request
- ready_i  input  1  bus completion
- addr_o  output  `RISCV_ADDR_WIDTH  bus address
- wdata_o  output  `RISCV_WORD_WIDTH  write data
- we_o  output  4  byte write enables; 4'hF for write, 4'h0 for read
- rdata_i  input  `RISCV_WORD_WIDTH  read data, valid when ready_i high
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. valid_o=0, tx_start_o=0, we_o=0, addr_o=0, wdata_o=0, tx_byte_o=0, busy_o=0. All counters cleared. An in-flight bus transaction or response is abandoned.
- Command formats; multi-byte fields are little-endian, LSB first:
  - 0x57 'W': 4 address bytes, then 4 data bytes. Response: 0x4B 'K'.
  - 0x52 'R': 4 address bytes. Response: 4 data bytes, LSB first.
  - Any other byte received in IDLE: ignored, no response.
- States: IDLE -> ADDR -> (DATA if write) -> BUS -> RESP -> IDLE.
  - A 2-bit byte counter indexes address and data bytes. The 4th address byte moves to DATA for a write, or to BUS for a read. The 4th data byte moves to BUS.
  - The address register is assembled in place: byte k goes to bits [8k+7:8k]. The data register is assembled the same way.
- Bus handshake:
  - valid_o rises in the cycle after entry to BUS, with addr_o, wdata_o and we_o stable.
  - valid_o stays high until a cycle where valid_o and ready_i are both high. That cycle completes the transaction; rdata_i is captured into the response register.
  - valid_o is low in the following cycle. There are no back-to-back requests.
  - No bus timeout: the bridge waits indefinitely for ready_i.
- Response:
  - tx_start_o pulses only when tx_busy_i is low and no tx_start_o was issued in the previous cycle. The guard cycle covers the uart core busy latency.
  - Read responses send byte index 0..3 from the captured word.
  - Return to IDLE after the last byte's tx_start_o pulse, without waiting for tx_busy_i to fall.
- rx_valid_i pulses during BUS or RESP: discarded, with no effect on state.
- Inter-byte timeout (ADDR/DATA only):
  - A counter clears on entry to ADDR and on every rx_valid_i, and increments on every other cycle.
  - When it reaches TIMEOUT: return to IDLE, no bus access, no response.
  - A byte arriving in the same cycle as expiry takes priority; no timeout occurs.
  - The counter saturates and never wraps.
- Partial-command bytes never alter addr_o/wdata_o while valid_o is high.

Optional Feature:
- Macro: UART_BUS_BRIDGE_CSUM_EN.
- Defined:
  - Each command carries one extra trailing byte equal to the XOR of all preceding command bytes, including the opcode. A CSUM state follows the last field byte.
  - Match: proceed to BUS.
  - Mismatch: no bus access; respond with the single byte 0x45 'E', then return to IDLE.
  - The timeout also applies in CSUM.
- Undefined: no CSUM state; commands exactly as listed above.

Test Plan:
- Write: bytes 57 10 00 00 00 EF BE AD DE -> one bus cycle with addr_o=0x00000010, wdata_o=0xDEADBEEF, we_o=4'hF; then one tx_start_o with tx_byte_o=0x4B.
- Read: bytes 52 08 00 00 00; slave returns rdata_i=0x12345678 with ready_i 3 cycles after valid_o -> we_o=0, valid_o held 3 cycles then dropped; tx bytes 78 56 34 12 in order, each only after tx_busy_i falls.
- Junk and abort: byte 0x41 in IDLE -> no tx or bus activity. With TIMEOUT=16, send 57 10 then stall 16 cycles -> busy_o falls, no bus cycle; a subsequent full read command works normally.
- Overlap: inject rx bytes 52 00 while valid_o is high and ready_i is withheld -> bytes ignored; the original transaction completes and its response is correct.
- Reset mid-operation: assert rst_n=0 for 1 cycle during the 2nd response byte -> next cycle valid_o=0, tx_start_o=0, busy_o=0; no further tx pulses.
- With UART_BUS_BRIDGE_CSUM_EN: 52 00 00 00 00 52 -> read of address 0 is performed. Same command with checksum 0x53 -> no bus cycle, single response 0x45.
